// File: rtl/store_buffer_cfwd_pkg.sv
// Shared defaults and helpers for the committed-drain store buffer with store-to-load forwarding.
package store_buffer_cfwd_pkg;

  localparam int unsigned SB_SIZE_DEF   = 4;
  localparam int unsigned SB_ADDR_W_DEF = 32;
  localparam int unsigned SB_DATA_W_DEF = 32;

  // Number of address bits that select a byte lane within one data word.
  function automatic int unsigned sb_lane_bits(input int unsigned data_w);
    return (data_w > 8) ? $clog2(data_w / 8) : 0;
  endfunction

endpackage

// File: rtl/sb_fwd_mux.sv
// Age-ordered per-byte forwarding select: walks entries oldest to youngest so the youngest hit per lane wins.
module sb_fwd_mux #(
  parameter  int unsigned SB_SIZE = 4,
  parameter  int unsigned DATA_W  = 32,
  localparam int unsigned STRB_W  = DATA_W / 8,
  localparam int unsigned PTR_W   = $clog2(SB_SIZE)
) (
  input  logic [SB_SIZE-1:0]             i_hit,
  input  logic [SB_SIZE-1:0][STRB_W-1:0] i_strb,
  input  logic [SB_SIZE-1:0][DATA_W-1:0] i_data,
  input  logic [PTR_W-1:0]               i_head,
  input  logic [PTR_W:0]                 i_cnt,
  output logic [DATA_W-1:0]              o_data,
  output logic [STRB_W-1:0]              o_strb
);

  always_comb begin
    logic [PTR_W-1:0] idx;
    o_data = '0;
    o_strb = '0;
    idx    = '0;
    for (int k = 0; k < SB_SIZE; k++) begin
      // Index arithmetic wraps naturally because SB_SIZE is a power of two.
      idx = i_head + PTR_W'(k);
      if (k < int'(i_cnt) && i_hit[idx]) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (i_strb[idx][b]) begin
            o_data[b*8 +: 8] = i_data[idx][b*8 +: 8];
            o_strb[b]        = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer_cfwd.sv
// Circular store buffer: speculative entries until ROB commit, only committed entries drain, flush drops the rest.
// Byte-granular store-to-load forwarding over all valid entries, newest store wins per lane.
module store_buffer_cfwd
  import store_buffer_cfwd_pkg::*;
#(
  parameter  int unsigned SB_SIZE = SB_SIZE_DEF,
  parameter  int unsigned ADDR_W  = SB_ADDR_W_DEF,
  parameter  int unsigned DATA_W  = SB_DATA_W_DEF,
  localparam int unsigned STRB_W  = DATA_W / 8,
  localparam int unsigned PTR_W   = $clog2(SB_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [STRB_W-1:0] in_strb_i,
  input  logic              commit_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [STRB_W-1:0] out_strb_o,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [STRB_W-1:0] fwd_strb_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned LSB = sb_lane_bits(DATA_W);
  localparam logic [ADDR_W-1:0] WORD_MASK = {ADDR_W{1'b1}} << LSB;
  localparam logic [PTR_W:0]    SIZE_P    = (PTR_W+1)'(SB_SIZE);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              valid;
    logic              committed;
  } entry_t;

  entry_t r_ent [SB_SIZE];

  logic [PTR_W:0]   r_head, r_cmt, r_tail;
  logic [PTR_W:0]   w_cnt, w_ccnt, w_cmt_nxt;
  logic [PTR_W-1:0] w_head_idx, w_cmt_idx, w_tail_idx;
  logic             w_push, w_pop, w_commit;

  logic [SB_SIZE-1:0]             w_hit;
  logic [SB_SIZE-1:0][STRB_W-1:0] w_strb;
  logic [SB_SIZE-1:0][DATA_W-1:0] w_data;

  assign w_cnt      = r_tail - r_head;
  assign w_ccnt     = r_cmt - r_head;
  assign w_head_idx = r_head[PTR_W-1:0];
  assign w_cmt_idx  = r_cmt[PTR_W-1:0];
  assign w_tail_idx = r_tail[PTR_W-1:0];

  assign in_ready_o  = (w_cnt < SIZE_P);
  assign out_valid_o = (w_ccnt != '0);
  assign empty_o     = (w_cnt == '0);
  assign full_o      = (r_tail[PTR_W] != r_head[PTR_W]) && (w_tail_idx == w_head_idx);

  assign w_push    = in_valid_i & in_ready_o & ~flush_i;
  assign w_pop     = out_valid_o & out_ready_i;
  assign w_commit  = commit_i & (w_ccnt < w_cnt);
  assign w_cmt_nxt = r_cmt + {{PTR_W{1'b0}}, w_commit};

  assign out_addr_o = r_ent[w_head_idx].addr;
  assign out_data_o = r_ent[w_head_idx].data;
  assign out_strb_o = r_ent[w_head_idx].strb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_cmt  <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + {{PTR_W{1'b0}}, w_pop};
      r_cmt  <= w_cmt_nxt;
      // Flush rewinds tail to the post-commit pointer, discarding speculative stores only.
      r_tail <= flush_i ? w_cmt_nxt : r_tail + {{PTR_W{1'b0}}, w_push};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SB_SIZE; i++) r_ent[i] <= '0;
    end else begin
      for (int i = 0; i < SB_SIZE; i++) begin
        if (w_push && w_tail_idx == PTR_W'(i)) begin
          r_ent[i].addr      <= in_addr_i;
          r_ent[i].data      <= in_data_i;
          r_ent[i].strb      <= in_strb_i;
          r_ent[i].valid     <= 1'b1;
          r_ent[i].committed <= 1'b0;
        end
        if (w_commit && w_cmt_idx == PTR_W'(i)) r_ent[i].committed <= 1'b1;
        if (w_pop && w_head_idx == PTR_W'(i)) begin
          r_ent[i].valid     <= 1'b0;
          r_ent[i].committed <= 1'b0;
        end
        if (flush_i && !r_ent[i].committed && !(w_commit && w_cmt_idx == PTR_W'(i)))
          r_ent[i].valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_hit  = '0;
    w_strb = '0;
    w_data = '0;
    for (int i = 0; i < SB_SIZE; i++) begin
      w_hit[i]  = r_ent[i].valid && (((r_ent[i].addr ^ ld_addr_i) & WORD_MASK) == '0);
      w_strb[i] = r_ent[i].strb;
      w_data[i] = r_ent[i].data;
    end
  end

  sb_fwd_mux #(
    .SB_SIZE (SB_SIZE),
    .DATA_W  (DATA_W)
  ) u_fwd_mux (
    .i_hit  (w_hit),
    .i_strb (w_strb),
    .i_data (w_data),
    .i_head (w_head_idx),
    .i_cnt  (w_cnt),
    .o_data (fwd_data_o),
    .o_strb (fwd_strb_o)
  );

endmodule

// File: tb/tb_store_buffer_cfwd.sv
// Directed bench for store_buffer_cfwd with a queue-based reference model and literal spot checks.
module tb_store_buffer_cfwd;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, in_valid_i, in_ready_o, commit_i;
  logic        out_valid_o, out_ready_i, empty_o, full_o;
  logic [31:0] in_addr_i, in_data_i, out_addr_o, out_data_o, ld_addr_i, fwd_data_o;
  logic [3:0]  in_strb_i, out_strb_o, fwd_strb_o;

  always #5 clk = ~clk;

  store_buffer_cfwd dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_addr_i(in_addr_i), .in_data_i(in_data_i), .in_strb_i(in_strb_i),
    .commit_i(commit_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o), .out_data_o(out_data_o), .out_strb_o(out_strb_o),
    .ld_addr_i(ld_addr_i), .fwd_data_o(fwd_data_o), .fwd_strb_o(fwd_strb_o),
    .empty_o(empty_o), .full_o(full_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          committed;
  } st_t;

  st_t mq[$];
  st_t drained[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stores in program order, oldest at index 0.
  int m_n, m_k;
  bit m_ov, m_push;
  st_t m_new;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      m_n    = mq.size();
      m_ov   = (m_n > 0) && mq[0].committed;
      m_push = in_valid_i && (m_n < 4) && !flush_i;
      m_k    = -1;
      for (int j = m_n - 1; j >= 0; j--) if (!mq[j].committed) m_k = j;
      if (commit_i) begin
        checks++;
        if (m_k < 0) begin
          failures++;
          $display("FAIL commit_legal actual=no_uncommitted required=uncommitted_store at %0t", $time);
        end else mq[m_k].committed = 1'b1;
      end
      if (m_ov && out_ready_i) begin
        drained.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (flush_i)
        while (mq.size() > 0 && !mq[mq.size()-1].committed) void'(mq.pop_back());
      if (m_push) begin
        m_new.addr = in_addr_i; m_new.data = in_data_i;
        m_new.strb = in_strb_i; m_new.committed = 1'b0;
        mq.push_back(m_new);
      end
    end
  end

  task automatic check_all();
    int          n;
    bit          ov;
    logic [31:0] fd;
    logic [3:0]  fs;
    n  = mq.size();
    ov = (n > 0) && mq[0].committed;
    fd = '0;
    fs = '0;
    foreach (mq[j]) begin
      if (mq[j].addr[31:2] == ld_addr_i[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (mq[j].strb[b]) begin
            fd[b*8 +: 8] = mq[j].data[b*8 +: 8];
            fs[b]        = 1'b1;
          end
        end
      end
    end
    chk("in_ready", 32'(in_ready_o), 32'(n < 4));
    chk("full", 32'(full_o), 32'(n == 4));
    chk("empty", 32'(empty_o), 32'(n == 0));
    chk("out_valid", 32'(out_valid_o), 32'(ov));
    chk("fwd_strb", 32'(fwd_strb_o), 32'(fs));
    chk("fwd_data", fwd_data_o, fd);
    if (ov) begin
      chk("out_addr", out_addr_o, mq[0].addr);
      chk("out_data", out_data_o, mq[0].data);
      chk("out_strb", 32'(out_strb_o), 32'(mq[0].strb));
    end
  endtask

  always @(negedge clk) begin
    #2;
    check_all();
  end

  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic c, input logic r, input logic f, input logic [31:0] ld);
    @(negedge clk);
    in_valid_i = v; in_addr_i = a; in_data_i = d; in_strb_i = s;
    commit_i = c; out_ready_i = r; flush_i = f; ld_addr_i = ld;
  endtask

  task automatic idle(input logic r, input logic [31:0] ld);
    cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, r, 1'b0, ld);
  endtask

  initial begin
    rst = 1'b1;
    in_valid_i = 0; in_addr_i = 0; in_data_i = 0; in_strb_i = 0;
    commit_i = 0; out_ready_i = 0; flush_i = 0; ld_addr_i = 0;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_fwd_strb", 32'(fwd_strb_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Push, commit, drain.
    cyc(1, 32'h100, 32'h11223344, 4'hF, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    #3 chk("t1_not_yet_valid", 32'(out_valid_o), 32'd0);
    idle(0, 0);
    #3;
    chk("t1_out_valid", 32'(out_valid_o), 32'd1);
    chk("t1_out_addr", out_addr_o, 32'h100);
    chk("t1_out_data", out_data_o, 32'h11223344);
    chk("t1_out_strb", 32'(out_strb_o), 32'hF);
    idle(1, 0);
    idle(0, 0);
    #3;
    chk("t1_empty", 32'(empty_o), 32'd1);
    chk("t1_drain_cnt", 32'(drained.size()), 32'd1);

    // Fill without commit, attempt a fifth push.
    for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 32'(4*i), 32'hC0DE0000 + 32'(i), 4'hF, 0, 0, 0, 0);
    cyc(1, 32'h3F0, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    #3;
    chk("t2_full", 32'(full_o), 32'd1);
    chk("t2_in_ready", 32'(in_ready_o), 32'd0);
    chk("t2_out_valid", 32'(out_valid_o), 32'd0);

    // Commit two then flush: the two committed stores survive.
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle(1, 0);
    #3;
    chk("t3_full", 32'(full_o), 32'd0);
    chk("t3_out_addr0", out_addr_o, 32'h300);
    idle(1, 0);
    #3 chk("t3_out_addr1", out_addr_o, 32'h304);
    idle(1, 0);
    #3 chk("t3_empty", 32'(empty_o), 32'd1);
    idle(1, 0);
    chk("t3_drain_cnt", 32'(drained.size()), 32'd3);
    chk("t3_drain1", drained[1].addr, 32'h300);
    chk("t3_drain2", drained[2].addr, 32'h304);

    // Byte-merge forwarding, youngest wins per lane; slot order wraps here.
    cyc(1, 32'h200, 32'hAAAAAAAA, 4'h3, 0, 0, 0, 0);
    cyc(1, 32'h200, 32'hBBBBBBBB, 4'h6, 0, 0, 0, 0);
    idle(0, 32'h200);
    #3;
    chk("t4_fwd_strb", 32'(fwd_strb_o), 32'h7);
    chk("t4_fwd_data", fwd_data_o, 32'h00BBBBAA);
    idle(0, 32'h203);
    #3 chk("t4_fwd_data_off", fwd_data_o, 32'h00BBBBAA);
    idle(0, 32'h204);
    #3 chk("t4_fwd_miss", 32'(fwd_strb_o), 32'h0);
    cyc(1, 32'h200, 32'hCCCCCCCC, 4'hF, 0, 0, 0, 32'h200);
    #3 chk("t4_push_invisible", fwd_data_o, 32'h00BBBBAA);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h200);
    idle(0, 32'h200);
    #3;
    chk("t4_flushed_empty", 32'(empty_o), 32'd1);
    chk("t4_flushed_fwd", 32'(fwd_strb_o), 32'h0);

    // Continuous stream across pointer wrap.
    for (int k = 0; k < 16; k++)
      cyc(k < 12, 32'h400 + 32'(4*k), 32'hD0000000 + 32'(k), 4'hF >> (k % 4),
          (k >= 1 && k <= 12), 1, 0, 32'h400 + 32'(4*((k > 0) ? k - 1 : 0)));
    idle(1, 0);
    idle(0, 0);
    chk("t5_drain_cnt", 32'(drained.size()), 32'd15);
    for (int j = 0; j < 12; j++) chk("t5_order", drained[3+j].addr, 32'h400 + 32'(4*j));

    // Flush with push and commit of the last speculative store.
    cyc(1, 32'h500, 32'h55555555, 4'hF, 0, 0, 0, 0);
    cyc(1, 32'h504, 32'h66666666, 4'hF, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 32'h508, 32'h77777777, 4'hF, 1, 0, 1, 0);
    idle(0, 0);
    #3 chk("t6_out_addr", out_addr_o, 32'h500);
    repeat (3) idle(1, 0);
    idle(0, 0);
    chk("t6_drain_cnt", 32'(drained.size()), 32'd17);
    chk("t6_drain_a", drained[15].addr, 32'h500);
    chk("t6_drain_b", drained[16].addr, 32'h504);

    // Reset with pending committed and speculative entries.
    cyc(1, 32'h600, 32'h12345678, 4'hF, 0, 0, 0, 32'h600);
    cyc(1, 32'h604, 32'h9ABCDEF0, 4'hF, 1, 0, 0, 32'h600);
    idle(0, 32'h600);
    @(negedge clk);
    rst = 1'b1;
    #3;
    chk("t7_empty", 32'(empty_o), 32'd1);
    chk("t7_out_valid", 32'(out_valid_o), 32'd0);
    chk("t7_fwd_strb", 32'(fwd_strb_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(0, 0);
    idle(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
